// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (DIV/REM unit), one quotient bit per cycle, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (adds a 1-cycle sign-fix state).
module seq_divider #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] q_reg;
  logic [WIDTH-1:0] r_reg;
  logic             dbz;
  logic [WIDTH:0]   r_shift;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic             accept;
  logic             last_iter;
`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             neg_q;
  logic             neg_r;
`endif

  always_comb begin
    dvd_mag = dividend;
    dvs_mag = divisor;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (dividend[WIDTH-1]) dvd_mag = -dividend;
    if (divisor[WIDTH-1])  dvs_mag = -divisor;
`endif
  end

  // Partial remainder stays below the divisor, so the shifted value fits in WIDTH+1 bits.
  assign r_shift   = {r_reg, dvd_sh[WIDTH-1]};
  assign trial     = r_shift - {1'b0, dvs};
  assign last_iter = (count == CW'(WIDTH - 1));
  assign accept    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (dbz) begin
          state_nxt = DONE;
        end else if (last_iter) begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          state_nxt = FIX;
`else
          state_nxt = DONE;
`endif
        end
      end
      FIX:  state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= '0;
      dvd_sh <= '0;
      dvs    <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      dbz    <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            count  <= '0;
            dvd_sh <= dvd_mag;
            dvs    <= dvs_mag;
            dbz    <= (divisor == '0);
            // Divide-by-zero result is loaded now; BUSY just spends its one cycle.
            if (divisor == '0) begin
              q_reg <= '1;
              r_reg <= dividend;
            end else begin
              q_reg <= '0;
              r_reg <= '0;
            end
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            neg_r <= dividend[WIDTH-1];
`endif
          end
        end
        BUSY: begin
          if (!dbz) begin
            r_reg  <= trial[WIDTH] ? r_shift[WIDTH-1:0] : trial[WIDTH-1:0];
            q_reg  <= {q_reg[WIDTH-2:0], ~trial[WIDTH]};
            dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
            count  <= count + 1'b1;
          end
        end
        FIX: begin
`ifdef SEQ_DIVIDER_SIGNED_EN
          if (neg_q) q_reg <= -q_reg;
          if (neg_r) r_reg <= -r_reg;
`endif
        end
        default: ;
      endcase
    end
  end

  assign quotient    = q_reg;
  assign remainder   = r_reg;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider at WIDTH=8: directed and random operations checked against an arithmetic model.
module tb_seq_divider;
  localparam int W = 8;
`ifdef SEQ_DIVIDER_SIGNED_EN
  localparam int LAT = W + 1;
`else
  localparam int LAT = W;
`endif

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int checks = 0;
  int errors = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid),
    .out_ready(out_ready), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z, output int lat);
    int sa, sb, iq, ir;
    if (b == 0) begin
      q = '1; r = a; z = 1'b1; lat = 1;
    end else begin
      z = 1'b0; lat = LAT;
`ifdef SEQ_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
      iq = sa / sb;
      ir = sa % sb;
`else
      sa = int'(a);
      sb = int'(b);
      iq = sa / sb;
      ir = sa % sb;
`endif
      q = iq[W-1:0];
      r = ir[W-1:0];
    end
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall, input bit hold,
                        output logic [W-1:0] q, output logic [W-1:0] r,
                        output logic z, output int lat, output bit proto_ok);
    int guard;
    proto_ok = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    if (!in_ready) proto_ok = 1'b0;
    in_valid = 1'b1; dividend = a; divisor = b; out_ready = 1'b0;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) proto_ok = 1'b0;
      if (hold) begin dividend = W'($urandom); divisor = W'($urandom); end
      @(posedge clk); #1; lat++;
    end
    q = quotient; r = remainder; z = div_by_zero;
    repeat (stall) begin
      if (hold) begin dividend = W'($urandom); divisor = W'($urandom); end
      @(posedge clk); #1;
      if (quotient !== q || remainder !== r || div_by_zero !== z ||
          out_valid !== 1'b1 || in_ready !== 1'b0) proto_ok = 1'b0;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) proto_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    checks++; if (quotient !== '0) begin errors++; $display("FAIL reset_quotient got %h want 00", quotient); end
    checks++; if (remainder !== '0) begin errors++; $display("FAIL reset_remainder got %h want 00", remainder); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got %b want 0", div_by_zero); end
  endtask

  task automatic test_directed();
    logic [W-1:0] ta [12] = '{8'd200, 8'd7, 8'd255, 8'd255, 8'd5, 8'd100, 8'h9C, 8'h80, 8'd100, 8'd0, 8'd255, 8'h80};
    logic [W-1:0] tb [12] = '{8'd7, 8'd200, 8'd1, 8'd255, 8'd0, 8'd9, 8'd7, 8'hFF, 8'hF9, 8'd5, 8'd0, 8'h01};
    logic [W-1:0] q, r, eq, er;
    logic z, ez;
    int lat, elat;
    bit ok;
    for (int i = 0; i < 12; i++) begin
      ref_div(ta[i], tb[i], eq, er, ez, elat);
      run_op(ta[i], tb[i], i % 3, 1'b0, q, r, z, lat, ok);
      checks++; if (q !== eq) begin errors++; $display("FAIL dir_quotient %0d/%0d got %h want %h", ta[i], tb[i], q, eq); end
      checks++; if (r !== er) begin errors++; $display("FAIL dir_remainder %0d/%0d got %h want %h", ta[i], tb[i], r, er); end
      checks++; if (z !== ez) begin errors++; $display("FAIL dir_dbz %0d/%0d got %b want %b", ta[i], tb[i], z, ez); end
      checks++; if (lat !== elat) begin errors++; $display("FAIL dir_latency %0d/%0d got %0d want %0d", ta[i], tb[i], lat, elat); end
      checks++; if (!ok) begin errors++; $display("FAIL dir_handshake %0d/%0d got bad want good", ta[i], tb[i]); end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] q, r;
    logic z;
    int lat;
    bit ok;
    run_op(8'd100, 8'd9, 5, 1'b1, q, r, z, lat, ok);
    checks++; if (q !== 8'd11) begin errors++; $display("FAIL bp_quotient got %0d want 11", q); end
    checks++; if (r !== 8'd1) begin errors++; $display("FAIL bp_remainder got %0d want 1", r); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL bp_latency got %0d want %0d", lat, LAT); end
    checks++; if (!ok) begin errors++; $display("FAIL bp_handshake got unstable want stable"); end
  endtask

  task automatic test_reset_midop();
    logic [W-1:0] q, r;
    logic z;
    int lat;
    bit ok;
    in_valid = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b want 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid got %b want 0", out_valid); end
    checks++; if (quotient !== '0 || remainder !== '0) begin errors++; $display("FAIL midrst_results got %h/%h want 00/00", quotient, remainder); end
    run_op(8'd50, 8'd5, 0, 1'b0, q, r, z, lat, ok);
    checks++; if (q !== 8'd10 || r !== 8'd0 || z !== 1'b0) begin errors++; $display("FAIL midrst_op got %0d r %0d z %b want 10 r 0 z 0", q, r, z); end
    checks++; if (lat !== LAT) begin errors++; $display("FAIL midrst_latency got %0d want %0d", lat, LAT); end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, q, r, eq, er;
    logic z, ez;
    int lat, elat, sel;
    bit ok;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h80;
      sel = $urandom_range(0, 9);
      case (sel)
        0: b = 8'd0;
        1: b = 8'd1;
        2: b = a;
        3: b = 8'hFF;
        default: b = W'($urandom);
      endcase
      ref_div(a, b, eq, er, ez, elat);
      run_op(a, b, $urandom_range(0, 3), bit'($urandom_range(0, 1)), q, r, z, lat, ok);
      checks++;
      if (q !== eq || r !== er || z !== ez) begin
        errors++;
        $display("FAIL rand_result %h/%h got q=%h r=%h z=%b want q=%h r=%h z=%b", a, b, q, r, z, eq, er, ez);
      end
      checks++; if (lat !== elat) begin errors++; $display("FAIL rand_latency %h/%h got %0d want %0d", a, b, lat, elat); end
      checks++; if (!ok) begin errors++; $display("FAIL rand_handshake %h/%h got bad want good", a, b); end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_midop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
